debounce_bank: RTL

Multi-channel, parametrised button conditioner for the calculator keypad and control buttons. Each channel synchronises a raw asynchronous input, debounces it with a consecutive-sample counter on a shared sample tick, and produces:
- a clean level;
- single-cycle press and release pulses;
- optional auto-repeat pulses while held.

It replaces per-button single-channel debouncers between the board pins and the input-decoding FSM.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_channel.sv | 172 +++++++++++++++++
 rtl/debounce_bank.sv | 80 ++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the debounce_bank button conditioner.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } ch_state_e;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, consecutive-sample debouncer and press/release FSM.
// Auto-repeat (REPEAT state, repeat counter, rpt pulses) exists only with DEBOUNCE_REPEAT_EN.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SAMPLES       = 8,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic rpt_o,
  output logic press_d_o
);

  localparam int MW = cnt_width(SAMPLES);

  if (SAMPLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_err
    $error("debounce_channel: illegal parameter configuration");
  end

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [MW-1:0] match_q, match_d;
  ch_state_e     state_q, state_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rpt_q, rpt_d;
`endif

  // A disagreeing sample extends the run; an agreeing one resets it.
  always_comb begin
    stable_d = stable_q;
    match_d  = match_q;
    if (tick_i) begin
      if (sync2_q != stable_q) begin
        if (match_q == MW'(SAMPLES - 1)) begin
          stable_d = ~stable_q;
          match_d  = '0;
        end else begin
          match_d = match_q + MW'(1);
        end
      end else begin
        match_d = '0;
      end
    end else begin
      match_d = match_q;
    end
  end

  // Release has priority over a repeat that would fire in the same cycle.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
    rcnt_d    = rcnt_q;
    rpt_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (stable_q) begin
          state_d = HELD;
          press_d = 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
          rcnt_d  = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (!stable_q) begin
          state_d   = IDLE;
          release_d = 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
          rcnt_d    = '0;
        end else if (tick_i) begin
          if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
            state_d = REPEAT;
            rpt_d   = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
`endif
        end else begin
          state_d = HELD;
        end
      end
      REPEAT: begin
        if (!stable_q) begin
          state_d   = IDLE;
          release_d = 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
          rcnt_d    = '0;
        end else if (tick_i) begin
          if (rcnt_q == RW'(REPEAT_PERIOD - 1)) begin
            rpt_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
`endif
        end else begin
          state_d = REPEAT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    level_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      match_q  <= '0;
    end else begin
      sync1_q  <= btn_raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      match_q  <= match_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      rcnt_q    <= '0;
      rpt_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef DEBOUNCE_REPEAT_EN
      rcnt_q    <= rcnt_d;
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign press_d_o = press_d & ~rst;
`ifdef DEBOUNCE_REPEAT_EN
  assign rpt_o     = rpt_q;
`else
  assign rpt_o     = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel button conditioner: shared sample prescaler plus one debounce_channel per input.
// Auto-repeat pulses are generated only when DEBOUNCE_REPEAT_EN is defined.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SAMPLES       = 8,
  parameter int TICK_DIV      = 1,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_raw_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] rpt_o,
  output logic                any_press_o
);

  logic                tick_s;
  logic [CHANNELS-1:0] press_d;
  logic                any_press_q;

  if (TICK_DIV <= 1) begin : g_tick_always
    assign tick_s = 1'b1;
  end else begin : g_prescaler
    localparam int PW = cnt_width(TICK_DIV - 1);
    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
      if (pre_q == PW'(TICK_DIV - 1)) begin
        pre_d = '0;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_d;
      end
    end

    assign tick_s = (pre_q == PW'(TICK_DIV - 1));
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .SAMPLES       (SAMPLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick_s),
      .btn_raw_i (btn_raw_i[g]),
      .level_o   (level_o[g]),
      .press_o   (press_o[g]),
      .release_o (release_o[g]),
      .rpt_o     (rpt_o[g]),
      .press_d_o (press_d[g])
    );
  end

  // Registered from the channels' next-state press so it lines up with press_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_d;
    end
  end

  assign any_press_o = any_press_q;

endmodule
